// File: rtl/clken_gen.sv
// Multi-channel clock-enable generator: per-channel integer divide (period DIV+1), SYNC phase alignment, free-running CNT.
// Defining CLKEN_NCO_EN adds fsel_i/finc_i and a per-channel phase-accumulator (NCO) mode.
module clken_gen #(
  parameter int NCH  = 4,
  parameter int DIVW = 8,
  parameter int CNTW = 16,
  parameter int ACCW = 16
) (
  input  logic                mclk_i,
  input  logic                reset_i,
  input  logic                sync_i,
  input  logic [NCH*DIVW-1:0] div_i,
`ifdef CLKEN_NCO_EN
  input  logic [NCH-1:0]      fsel_i,
  input  logic [NCH*ACCW-1:0] finc_i,
`endif
  output logic [NCH-1:0]      cen_o,
  output logic [NCH-1:0]      clksq_o,
  output logic [CNTW-1:0]     cnt_o
);

  logic [NCH-1:0][DIVW-1:0] div_cnt_q, div_cnt_d;
  logic [NCH-1:0]           cen_q, cen_d;
  logic [NCH-1:0]           clksq_q, clksq_d;
  logic [CNTW-1:0]          cnt_q, cnt_d;
`ifdef CLKEN_NCO_EN
  logic [NCH-1:0][ACCW-1:0] acc_q, acc_d;
  logic [ACCW:0]            nco_sum;
`endif

  always_comb begin
    div_cnt_d = div_cnt_q;
    cen_d     = '0;
    clksq_d   = clksq_q;
`ifdef CLKEN_NCO_EN
    acc_d     = acc_q;
    nco_sum   = '0;
`endif
    for (int i = 0; i < NCH; i++) begin
`ifdef CLKEN_NCO_EN
      nco_sum = {1'b0, acc_q[i]} + {1'b0, finc_i[i*ACCW +: ACCW]};
`endif
      // SYNC restarts both the divider and the accumulator so reselecting a mode starts in phase
      if (sync_i) begin
        div_cnt_d[i] = '0;
        clksq_d[i]   = 1'b0;
`ifdef CLKEN_NCO_EN
        acc_d[i]     = '0;
`endif
      end
`ifdef CLKEN_NCO_EN
      else if (fsel_i[i]) begin
        acc_d[i]   = nco_sum[ACCW-1:0];
        cen_d[i]   = nco_sum[ACCW];
        clksq_d[i] = clksq_q[i] ^ nco_sum[ACCW];
      end
`endif
      // >= rather than == so a DIV lowered below the running count fires on the next edge
      else if (div_cnt_q[i] >= div_i[i*DIVW +: DIVW]) begin
        div_cnt_d[i] = '0;
        cen_d[i]     = 1'b1;
        clksq_d[i]   = ~clksq_q[i];
      end else begin
        div_cnt_d[i] = div_cnt_q[i] + DIVW'(1);
      end
    end
  end

  always_comb begin
    cnt_d = sync_i ? '0 : cnt_q + CNTW'(1);
  end

  always_ff @(posedge mclk_i or posedge reset_i) begin
    if (reset_i) begin
      div_cnt_q <= '0;
      cen_q     <= '0;
      clksq_q   <= '0;
      cnt_q     <= '0;
`ifdef CLKEN_NCO_EN
      acc_q     <= '0;
`endif
    end else begin
      div_cnt_q <= div_cnt_d;
      cen_q     <= cen_d;
      clksq_q   <= clksq_d;
      cnt_q     <= cnt_d;
`ifdef CLKEN_NCO_EN
      acc_q     <= acc_d;
`endif
    end
  end

  assign cen_o   = cen_q;
  assign clksq_o = clksq_q;
  assign cnt_o   = cnt_q;

endmodule

// File: tb/tb_clken_gen.sv
// Directed bench for clken_gen: expectations are queued as each edge is driven and checked just after it.
module tb_clken_gen;
  localparam int NCH  = 4;
  localparam int DIVW = 8;
  localparam int CNTW = 16;
  localparam int ACCW = 16;

  logic                mclk_i  = 1'b0;
  logic                reset_i = 1'b1;
  logic                sync_i  = 1'b0;
  logic [NCH*DIVW-1:0] div_i   = '0;
  logic [NCH-1:0]      cen_o;
  logic [NCH-1:0]      clksq_o;
  logic [CNTW-1:0]     cnt_o;
`ifdef CLKEN_NCO_EN
  logic [NCH-1:0]      fsel_i  = '0;
  logic [NCH*ACCW-1:0] finc_i  = '0;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [NCH-1:0]  cen;
    logic [NCH-1:0]  clksq;
    logic [NCH-1:0]  mask;
    logic [CNTW-1:0] cnt;
    bit              cnt_chk;
    string           tag;
  } exp_t;

  exp_t exp_q[$];

  clken_gen #(.NCH(NCH), .DIVW(DIVW), .CNTW(CNTW), .ACCW(ACCW)) dut (
    .mclk_i  (mclk_i),
    .reset_i (reset_i),
    .sync_i  (sync_i),
    .div_i   (div_i),
`ifdef CLKEN_NCO_EN
    .fsel_i  (fsel_i),
    .finc_i  (finc_i),
`endif
    .cen_o   (cen_o),
    .clksq_o (clksq_o),
    .cnt_o   (cnt_o)
  );

  always #5 mclk_i = ~mclk_i;

  // Steady-state expectation n edges after a restart: channel of period P pulses at multiples of P
  function automatic exp_t fexp(int n, logic [NCH*DIVW-1:0] divs, string tag);
    exp_t e;
    e.mask    = '1;
    e.cnt     = CNTW'(n);
    e.cnt_chk = 1'b1;
    e.tag     = tag;
    e.cen     = '0;
    e.clksq   = '0;
    for (int i = 0; i < NCH; i++) begin
      int p;
      p = int'(divs[i*DIVW +: DIVW]) + 1;
      e.cen[i]   = ((n % p) == 0);
      e.clksq[i] = (((n / p) % 2) != 0);
    end
    return e;
  endfunction

  function automatic exp_t zexp(string tag);
    exp_t e;
    e.mask    = '1;
    e.cen     = '0;
    e.clksq   = '0;
    e.cnt     = '0;
    e.cnt_chk = 1'b1;
    e.tag     = tag;
    return e;
  endfunction

  task automatic compare_head();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: got 0 entries, expected 1");
    end else begin
      e = exp_q.pop_front();
      checks++;
      assert ((cen_o & e.mask) === (e.cen & e.mask))
      else begin
        errors++;
        $error("FAIL %s cen: got %b expected %b mask %b", e.tag, cen_o, e.cen, e.mask);
      end
      checks++;
      assert ((clksq_o & e.mask) === (e.clksq & e.mask))
      else begin
        errors++;
        $error("FAIL %s clksq: got %b expected %b mask %b", e.tag, clksq_o, e.clksq, e.mask);
      end
      if (e.cnt_chk) begin
        checks++;
        assert (cnt_o === e.cnt)
        else begin
          errors++;
          $error("FAIL %s cnt: got %h expected %h", e.tag, cnt_o, e.cnt);
        end
      end
    end
  endtask

  task automatic step(exp_t e);
    exp_q.push_back(e);
    @(posedge mclk_i);
    #1;
    compare_head();
  endtask

  task automatic check_zero(string tag);
    checks++;
    assert (cen_o === '0)
    else begin errors++; $error("FAIL %s cen: got %b expected 0", tag, cen_o); end
    checks++;
    assert (clksq_o === '0)
    else begin errors++; $error("FAIL %s clksq: got %b expected 0", tag, clksq_o); end
    checks++;
    assert (cnt_o === '0)
    else begin errors++; $error("FAIL %s cnt: got %h expected 0", tag, cnt_o); end
  endtask

  initial begin
    exp_t e;

    // T1: basic ratios from reset
    div_i = {8'd255, 8'd3, 8'd1, 8'd0};
    #2;
    check_zero("reset_hold");
    @(negedge mclk_i);
    reset_i = 1'b0;
    for (int n = 1; n <= 520; n++) step(fexp(n, div_i, "t1"));

    // T2: SYNC lands on ch2 terminal-count edge (edge 524)
    for (int n = 521; n <= 523; n++) step(fexp(n, div_i, "t2_pre"));
    sync_i = 1'b1;
    step(zexp("t2_sync"));
    sync_i = 1'b0;
    for (int m = 1; m <= 8; m++) step(fexp(m, div_i, "t2_post"));

    // T3: ch1 DIV 7 -> 2 with cnt1 = 5
    sync_i = 1'b1;
    step(zexp("t3_sync"));
    sync_i = 1'b0;
    div_i[15:8] = 8'd7;
    for (int m = 1; m <= 5; m++) begin
      e = fexp(m, div_i, "t3_run");
      e.cen[1]   = 1'b0;
      e.clksq[1] = 1'b0;
      step(e);
    end
    div_i[15:8] = 8'd2;
    for (int m = 6; m <= 15; m++) begin
      e = fexp(m, div_i, "t3_low");
      e.cen[1]   = (((m - 6) % 3) == 0);
      e.clksq[1] = ((((m - 6) / 3) % 2) == 0);
      step(e);
    end

    // T4: async reset between edges, then T5 CNT wrap from that release
    #2;
    reset_i = 1'b1;
    #1;
    check_zero("t4_async");
    @(negedge mclk_i);
    reset_i = 1'b0;
    for (int n = 1; n <= 65537; n++) step(fexp(n, div_i, (n <= 12) ? "t4_release" : "t5_wrap"));

`ifdef CLKEN_NCO_EN
    begin
      int  pulses;
      int  last;
      longint f;
      // T6: ch0 NCO, FINC = 0x4000 gives an exact divide-by-4
      sync_i        = 1'b1;
      fsel_i        = 4'b0001;
      finc_i[15:0]  = 16'h4000;
      step(zexp("t6_sync"));
      sync_i = 1'b0;
      for (int m = 1; m <= 16; m++) begin
        e = fexp(m, div_i, "t6_quarter");
        e.cen[0]   = ((m % 4) == 0);
        e.clksq[0] = (((m / 4) % 2) != 0);
        step(e);
      end
      // FINC = 0x5555: pulse count is floor(m*F/2^16)
      f = 64'd21845;
      sync_i       = 1'b1;
      finc_i[15:0] = 16'h5555;
      step(zexp("t6_sync2"));
      sync_i = 1'b0;
      pulses = 0;
      last   = 0;
      for (int m = 1; m <= 6144; m++) begin
        e = zexp("t6_frac");
        e.mask     = 4'b0001;
        e.cnt      = CNTW'(m);
        e.cen[0]   = (((longint'(m) * f) >> 16) != ((longint'(m - 1) * f) >> 16));
        e.clksq[0] = ((((longint'(m) * f) >> 16) % 2) != 0);
        step(e);
        if (cen_o[0]) begin
          pulses++;
          checks++;
          assert ((m - last) == 3 || (m - last) == 4)
          else begin errors++; $error("FAIL t6_spacing: got %0d expected 3 or 4", m - last); end
          last = m;
        end
      end
      checks++;
      assert (longint'(pulses) == ((longint'(6144) * f) >> 16))
      else begin errors++; $error("FAIL t6_count: got %0d expected %0d", pulses, (longint'(6144) * f) >> 16); end
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    errors++;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
